seq_shifter: RTL and testbench

- Multi-cycle iterative shift engine: the sequential counterpart to the team's single-cycle combinational barrel shifter.
- Shifts one bit position per clock, so it trades latency for area.
- Adds rotate-left, the inverse of rotate-right.
- Sits behind a valid/ready request port and a valid/ready result port, so it can be used as a slow ALU shift unit in npc.

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_step.sv | 50 +++++
 rtl/seq_shifter.sv | 103 ++++++++++
 tb/tb_seq_shifter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift engine: operation codes and FSM states.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SLL  = 3'b000,
        OP_SRL  = 3'b001,
        OP_SRA  = 3'b010,
        OP_ROR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_PASS = 3'b101
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Codes 101..111 all collapse onto PASS.
    function automatic op_t decode_op(input logic [2:0] raw);
        return (raw > 3'b100) ? OP_PASS : op_t'(raw);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step of the shift engine: moves the operand by one bit,
// or by two bits when 'two' is set.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  op_t              op,
    input  logic             two,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;

    always_comb begin
        q1 = d;
        q2 = d;
        unique case (op)
            OP_SLL: begin
                q1 = {d[WIDTH-2:0], 1'b0};
                q2 = {d[WIDTH-3:0], 2'b00};
            end
            OP_SRL: begin
                q1 = {1'b0, d[WIDTH-1:1]};
                q2 = {2'b00, d[WIDTH-1:2]};
            end
            OP_SRA: begin
                q1 = {d[WIDTH-1], d[WIDTH-1:1]};
                q2 = {{2{d[WIDTH-1]}}, d[WIDTH-1:2]};
            end
            OP_ROR: begin
                q1 = {d[0], d[WIDTH-1:1]};
                q2 = {d[1:0], d[WIDTH-1:2]};
            end
            OP_ROL: begin
                q1 = {d[WIDTH-2:0], d[WIDTH-1]};
                q2 = {d[WIDTH-3:0], d[WIDTH-1:WIDTH-2]};
            end
            default: begin
                q1 = d;
                q2 = d;
            end
        endcase
    end

    assign q = two ? q2 : q1;

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate engine behind valid/ready request and result ports.
// Define SEQ_SHIFTER_FAST_EN to retire two bit positions per cycle where possible.
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] step_q;
    logic [AMT_W-1:0] cnt_q;
    op_t              op_q;
    op_t              op_in;
    logic             two;
    logic             last;

    assign op_in = decode_op(in_op);

`ifdef SEQ_SHIFTER_FAST_EN
    assign two  = (cnt_q >= AMT_W'(2));
    assign last = (cnt_q <= AMT_W'(2));
`else
    assign two  = 1'b0;
    assign last = (cnt_q == AMT_W'(1));
`endif

    shift_step #(.WIDTH(WIDTH)) u_step (
        .d   (data_q),
        .op  (op_q),
        .two (two),
        .q   (step_q)
    );

    // The working register doubles as the result register; it is frozen in DONE.
    assign out_data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            op_q      <= OP_SLL;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        cnt_q    <= in_amt;
                        op_q     <= op_in;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (in_amt == '0 || op_in == OP_PASS) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_q <= step_q;
                    cnt_q  <= cnt_q - (two ? AMT_W'(2) : AMT_W'(1));
                    if (last) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter (WIDTH=8); expectations are hand-computed.
module tb_seq_shifter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int errors = 0;
    int checks = 0;

    seq_shifter #(.WIDTH(8), .AMT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [2:0] amt, input logic [2:0] op);
        if (amt == 3'd0 || op > 3'b100) return 1;
`ifdef SEQ_SHIFTER_FAST_EN
        return (int'(amt) + 1) / 2 + 1;
`else
        return int'(amt) + 1;
`endif
    endfunction

    // Issue one request, measure edges from accept to result handshake, check data.
    task automatic run(input string tag, input logic [7:0] d, input logic [2:0] a,
                       input logic [2:0] op, input logic [7:0] exp);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_amt   = ~a;
        in_op    = 3'b000;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_latency(a, op));
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, exp});
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = '0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("sll3",   8'h96, 3'd3, 3'b000, 8'hB0);
        run("sra3",   8'h96, 3'd3, 3'b010, 8'hF2);
        run("srl3",   8'h96, 3'd3, 3'b001, 8'h12);
        run("ror1",   8'h81, 3'd1, 3'b011, 8'hC0);
        run("rol1",   8'h81, 3'd1, 3'b100, 8'h03);
        run("rol5",   8'h5A, 3'd5, 3'b100, 8'h4B);
        run("ror5",   8'h4B, 3'd5, 3'b011, 8'h5A);
        run("zero",   8'h3C, 3'd0, 3'b000, 8'h3C);
        run("pass7",  8'h3C, 3'd6, 3'b111, 8'h3C);
        run("pass5",  8'hA5, 3'd2, 3'b101, 8'hA5);
        run("sra7",   8'h80, 3'd7, 3'b010, 8'hFF);
        run("sll7",   8'h01, 3'd7, 3'b000, 8'h80);
        run("srl7",   8'hFF, 3'd7, 3'b001, 8'h01);
        run("rol7",   8'h81, 3'd7, 3'b100, 8'hC0);
        run("ror2",   8'h01, 3'd2, 3'b011, 8'h40);

        // Back-pressure: result held in DONE, stray request ignored.
        out_ready = 1'b0;
        run("bp", 8'h96, 3'd3, 3'b000, 8'hB0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i == 4);
            in_data  = 8'h11;
            in_amt   = 3'd1;
            in_op    = 3'b001;
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_data", {24'd0, out_data}, 32'hB0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        run("after_bp", 8'h0F, 3'd4, 3'b100, 8'hF0);

        // Reset during SHIFT.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_amt   = 3'd7;
        in_op    = 3'b000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rs_out_valid", {31'd0, out_valid}, 32'd0);
        check("rs_busy", {31'd0, busy}, 32'd0);
        check("rs_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rs", 8'h01, 3'd7, 3'b000, 8'h80);

        // Reset while holding a result in DONE.
        out_ready = 1'b0;
        run("rd", 8'hC3, 3'd2, 3'b011, 8'hF0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rd_out_valid", {31'd0, out_valid}, 32'd0);
        check("rd_busy", {31'd0, busy}, 32'd0);
        check("rd_in_ready", {31'd0, in_ready}, 32'd1);
        check("rd_out_data", {24'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        run("post_rd", 8'h96, 3'd3, 3'b010, 8'hF2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
